// File: rtl/fft_frame_driver.sv
// Ping-pong sample buffer that streams 8-sample frames into the FFT tile
// and returns the tile's packed magnitude word on a valid/ready port.
module fft_frame_driver #(
  parameter int N_SAMPLES   = 8,
  parameter int FRAME_LEN   = 16,
  parameter int RESULT_SLOT = 12,
  parameter int SAMPLE_W    = 8,
  parameter int SPEC_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                tile_rst_n,
  output logic                tile_ena,
  output logic [SAMPLE_W-1:0] tile_ui,
  input  logic [SPEC_W-1:0]   tile_spec,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SPEC_W-1:0]   m_spec,
  output logic                overrun,
  output logic                busy
);

  localparam int SW = $clog2(FRAME_LEN);
  localparam int FW = $clog2(N_SAMPLES + 1);
  localparam int AW = $clog2(N_SAMPLES);

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    STREAM
  } state_t;

  state_t            state, state_nx;
  logic [SW-1:0]     slot, slot_nx;
  logic              wr_bank, rd_bank;
  logic [FW-1:0]     fill [2];
  logic [SAMPLE_W-1:0] mem [2][N_SAMPLES];

  logic s_fire;
  logic streaming;
  logic last_slot;
  logic cap;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign streaming  = (state == STREAM);
  assign last_slot  = streaming && (slot == SW'(FRAME_LEN - 1));
  assign cap        = streaming && (slot == SW'(RESULT_SLOT));
  assign s_ready    = (state != INIT) && (fill[wr_bank] < FW'(N_SAMPLES));
  assign s_fire     = s_valid && s_ready;
  assign wr_idx     = fill[wr_bank][AW-1:0];
  assign rd_idx     = slot[AW-1:0];

  assign tile_ena   = streaming;
  assign busy       = streaming;
  // rst_n gates the tile reset combinationally so it drops in the same cycle
  assign tile_rst_n = rst_n && (state != INIT);
  assign tile_ui    = (streaming && slot < SW'(N_SAMPLES))
                    ? mem[rd_bank][rd_idx] : '0;

  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    unique case (state)
      INIT: begin
        state_nx = IDLE;
        slot_nx  = '0;
      end
      IDLE: begin
        slot_nx = '0;
        if (fill[rd_bank] == FW'(N_SAMPLES))
          state_nx = STREAM;
      end
      STREAM: begin
        slot_nx = slot + SW'(1);
        if (last_slot) begin
          slot_nx = '0;
          if (fill[~rd_bank] != FW'(N_SAMPLES))
            state_nx = IDLE;
        end
      end
      default: begin
        state_nx = INIT;
        slot_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= INIT;
      slot    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      fill[0] <= '0;
      fill[1] <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      if (s_fire) begin
        fill[wr_bank] <= fill[wr_bank] + FW'(1);
        if (fill[wr_bank] == FW'(N_SAMPLES - 1))
          wr_bank <= ~wr_bank;
      end
      if (last_slot) begin
        fill[rd_bank] <= '0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire)
      mem[wr_bank][wr_idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_spec  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (cap) begin
        m_spec  <= tile_spec;
        m_valid <= 1'b1;
        overrun <= m_valid && !m_ready;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_driver.sv
// Bench for fft_frame_driver: directed steps with random data,
// checked against a frame-schedule reference model.
module tb_fft_frame_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        tile_rst_n;
  logic        tile_ena;
  logic [7:0]  tile_ui;
  logic [15:0] tile_spec;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_spec;
  logic        overrun;
  logic        busy;

  fft_frame_driver dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .tile_rst_n(tile_rst_n),
    .tile_ena(tile_ena),
    .tile_ui(tile_ui),
    .tile_spec(tile_spec),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_spec(m_spec),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // reference model state
  int unsigned cyc = 0;
  int unsigned fstart[$];
  logic [7:0]  fdata[$];
  logic [7:0]  part[$];
  int          held = 0;
  int unsigned last_end = 0;
  logic        exp_mv = 1'b0;
  logic        exp_ov = 1'b0;
  logic [15:0] exp_ms = '0;
  bit          in_init = 1'b1;
  bit          acc = 1'b0;
  bit          mr_mode = 1'b0;
  logic [15:0] cap_q[$];

  // observations of the DUT for directed checks
  int          ena_run = 0;
  int          runs[$];
  int unsigned mv_rises[$];
  logic        prev_mv = 1'b0;
  int          mv_hi = 0;
  int          ov_cnt = 0;
  int          nrdy = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit at_slot(input int s);
    return fstart.size() > 0 && cyc >= fstart[0] &&
           int'(cyc - fstart[0]) == s;
  endfunction

  task automatic clear_obs();
    runs.delete();
    mv_rises.delete();
    mv_hi = 0;
    ov_cnt = 0;
    nrdy = 0;
    ena_run = 0;
  endtask

  // one clock: check outputs mid-cycle, then advance the model
  task automatic cycle();
    bit         e_ena;
    int         slot;
    logic [7:0] e_ui;
    bit         e_rdy;
    int unsigned st;
    tile_spec = 16'($urandom);
    if (mr_mode) m_ready = 1'($urandom_range(1));
    #1;
    e_ena = fstart.size() > 0 && cyc >= fstart[0];
    slot  = e_ena ? int'(cyc - fstart[0]) : 0;
    e_ui  = (e_ena && slot < 8) ? fdata[slot] : 8'd0;
    e_rdy = !in_init && held < 16;
    chk("tile_ena", tile_ena, e_ena);
    chk("busy", busy, e_ena);
    chk("tile_ui", tile_ui, e_ui);
    chk("s_ready", s_ready, e_rdy);
    chk("tile_rst_n", tile_rst_n, rst_n && !in_init);
    chk("m_valid", m_valid, exp_mv);
    chk("overrun", overrun, exp_ov);
    if (exp_mv) chk("m_spec", m_spec, exp_ms);

    if (tile_ena) ena_run++;
    else if (ena_run > 0) begin
      runs.push_back(ena_run);
      ena_run = 0;
    end
    if (m_valid && !prev_mv) mv_rises.push_back(cyc);
    prev_mv = m_valid;
    if (m_valid) mv_hi++;
    if (overrun) ov_cnt++;
    if (s_valid && !s_ready && rst_n) nrdy++;

    acc = 1'b0;
    if (!rst_n) begin
      fstart.delete();
      fdata.delete();
      part.delete();
      held = 0;
      exp_mv = 1'b0;
      exp_ov = 1'b0;
      in_init = 1'b1;
    end else begin
      in_init = 1'b0;
      exp_ov = 1'b0;
      if (e_ena && slot == 12) begin
        exp_ov = exp_mv && !m_ready;
        exp_ms = tile_spec;
        exp_mv = 1'b1;
        cap_q.push_back(tile_spec);
      end else if (exp_mv && m_ready) begin
        exp_mv = 1'b0;
      end
      if (s_valid && e_rdy) begin
        acc = 1'b1;
        part.push_back(s_data);
        held++;
        if (part.size() == 8) begin
          st = (cyc + 2 > last_end) ? cyc + 2 : last_end;
          fstart.push_back(st);
          foreach (part[i]) fdata.push_back(part[i]);
          part.delete();
          last_end = st + 16;
        end
      end
      if (e_ena && slot == 15) begin
        void'(fstart.pop_front());
        repeat (8) void'(fdata.pop_front());
        held -= 8;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int n, input int gap, input bit ramp);
    int k = 0;
    int b = 0;
    logic [7:0] nxt;
    nxt = ramp ? 8'd8 : 8'($urandom);
    while (k < n && b < 400) begin
      s_valid = ($urandom_range(99) >= gap);
      s_data  = nxt;
      cycle();
      if (acc) begin
        k++;
        nxt = ramp ? 8'((k + 1) * 8) : 8'($urandom);
      end
      b++;
    end
    s_valid = 1'b0;
    chk("send_done", k, n);
  endtask

  task automatic drain();
    int b = 0;
    s_valid = 1'b0;
    while (fstart.size() != 0 && b < 200) begin
      cycle();
      b++;
    end
    repeat (3) cycle();
    chk("drain_done", fstart.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    tile_spec = '0;
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // T1 reset window and INIT
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    #1;
    chk("t1_idle_ready", s_ready, 1);
    chk("t1_idle_rst_n", tile_rst_n, 1);
    chk("t1_idle_ena", tile_ena, 0);

    // T2 single ramp frame
    m_ready = 1'b1;
    clear_obs();
    send(8, 0, 1);
    drain();
    chk("t2_runs", runs.size(), 1);
    chk("t2_runlen", runs.size() > 0 ? runs[0] : 0, 16);
    chk("t2_mv_pulses", mv_rises.size(), 1);
    chk("t2_mv_width", mv_hi, 1);

    // T3 back-to-back frames
    clear_obs();
    send(16, 0, 0);
    chk("t3_sready_drop", nrdy, 0);
    drain();
    chk("t3_runs", runs.size(), 1);
    chk("t3_runlen", runs.size() > 0 ? runs[0] : 0, 32);
    chk("t3_mv_pulses", mv_rises.size(), 2);
    chk("t3_mv_spacing",
        mv_rises.size() == 2 ? mv_rises[1] - mv_rises[0] : 0, 16);

    // T4 backpressure with three frames
    clear_obs();
    send(24, 0, 0);
    chk("t4_nready_cycles", nrdy, 9);
    drain();
    chk("t4_runlen", runs.size() > 0 ? runs[0] : 0, 48);

    // T5 overrun with m_ready low
    m_ready = 1'b0;
    clear_obs();
    cap_q.delete();
    send(16, 30, 0);
    drain();
    chk("t5_overrun_cnt", ov_cnt, 1);
    chk("t5_captures", cap_q.size(), 2);
    chk("t5_m_valid", m_valid, 1);
    chk("t5_m_spec", m_spec, cap_q.size() == 2 ? cap_q[1] : 16'hxxxx);

    // T6 reset mid-frame with a result pending
    send(8, 0, 0);
    begin
      int b = 0;
      while (!at_slot(5) && b < 40) begin
        cycle();
        b++;
      end
      chk("t6_reached_slot5", at_slot(5), 1);
    end
    rst_n = 1'b0;
    cycle();
    #1;
    chk("t6_ena_after_rst", tile_ena, 0);
    chk("t6_mv_after_rst", m_valid, 0);
    rst_n = 1'b1;
    cycle();
    cycle();
    m_ready = 1'b1;
    cap_q.delete();
    send(8, 20, 0);
    drain();
    chk("t6_captures", cap_q.size(), 1);

    // randomized traffic with random sink stalls
    mr_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      send(8 * int'($urandom_range(1, 3)), int'($urandom_range(0, 50)), 0);
      repeat ($urandom_range(0, 20)) cycle();
    end
    mr_mode = 1'b0;
    m_ready = 1'b1;
    drain();
    chk("final_m_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
